// File: rtl/jtag_debug_sys_avalon_pkg.sv
// Shared definitions for the JTAG debug Avalon-MM host: FSM state encoding
// and a width helper used to size the stall/latency counter.
package jtag_debug_sys_avalon_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    RDWAIT = ST_RDWAIT,
    RESP   = ST_RESP
  } state_t;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/jtag_debug_sys_avalon_host_if.sv
// Command, response and Avalon-MM bus signals of the debug host.
// master = the host itself, slave = everything around it (decoder,
// response consumer and the Avalon slave).
interface jtag_debug_sys_avalon_host_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
);
  import jtag_debug_sys_avalon_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_writedata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_readdata;
  logic              rsp_error;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata, rsp_ready,
           readdata, waitrequest,
    output cmd_ready, rsp_valid, rsp_readdata, rsp_error,
           address, chipselect, write_n, writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata, rsp_ready,
           readdata, waitrequest,
    input  cmd_ready, rsp_valid, rsp_readdata, rsp_error,
           address, chipselect, write_n, writedata
  );

endinterface

// File: rtl/jtag_debug_sys_avalon_host.sv
// Avalon-MM host for the JTAG debug system. Takes one read/write command at a
// time, runs a single Avalon access (honouring waitrequest, an optional stall
// timeout and a fixed slave read latency) and returns readdata or a write
// acknowledge on the response channel.
module jtag_debug_sys_avalon_host
  import jtag_debug_sys_avalon_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic clk,
  input  logic reset,
  jtag_debug_sys_avalon_host_if.master bus
);

  // One counter serves both the stall timeout and the read-latency wait.
  localparam int TO_W  = clog2(TIMEOUT + 1);
  localparam int RL_W  = clog2(READ_LATENCY + 1);
  localparam int MAX_W = (TO_W > RL_W) ? TO_W : RL_W;
  localparam int CNT_W = (MAX_W < 1) ? 1 : MAX_W;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RL_LAST = CNT_W'(READ_LATENCY - 1);

  state_t            state;
  state_t            state_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt;

  logic accept;
  logic cnt_clr;
  logic cnt_inc;
  logic cap_rd;
  logic cap_wr;
  logic cap_err;

  // State register; reset drops any access or response in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode plus the bus strobes, which follow the state directly
  // so that reset clears them without waiting for a clock.
  always_comb begin
    state_d        = state;
    accept         = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    cap_rd         = 1'b0;
    cap_wr         = 1'b0;
    cap_err        = 1'b0;
    bus.cmd_ready  = (state == IDLE);
    bus.rsp_valid  = (state == RESP);
    bus.chipselect = (state == ACCESS);
    bus.write_n    = !((state == ACCESS) && wr_q);
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.waitrequest) begin
          if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
            cap_err = 1'b1;
            state_d = RESP;
          end else begin
            cnt_inc = 1'b1;
          end
        end else if (wr_q) begin
          cap_wr  = 1'b1;
          state_d = RESP;
        end else if (READ_LATENCY == 0) begin
          cap_rd  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_clr = 1'b1;
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (cnt == RL_LAST) begin
          cap_rd  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, shared counter and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        wr_q    <= bus.cmd_write;
        addr_q  <= bus.cmd_address;
        wdata_q <= bus.cmd_writedata;
      end
      if (accept || cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (cap_rd) begin
        rdata_q <= bus.readdata;
        err_q   <= 1'b0;
      end else if (cap_wr) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end else if (cap_err) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign bus.address      = addr_q;
  assign bus.writedata    = wdata_q;
  assign bus.rsp_readdata = rdata_q;
  assign bus.rsp_error    = err_q;

endmodule

// File: tb/tb_jtag_debug_sys_avalon_host.sv
// Bench for jtag_debug_sys_avalon_host. Two hosts are built: A (PIO slave,
// readdata combinational, READ_LATENCY=0) and B (slave answering two cycles
// after the access, READ_LATENCY=2); both use TIMEOUT=8. One command stream is
// steered to the selected host. A transaction-level model predicts, for every
// cycle, the handshake/strobe levels and the response contents.
module tb_jtag_debug_sys_avalon_host;

  localparam int TO   = 8;
  localparam int RL_B = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  jtag_debug_sys_avalon_host_if #(.ADDR_W(2), .DATA_W(32)) ifa ();
  jtag_debug_sys_avalon_host_if #(.ADDR_W(2), .DATA_W(32)) ifb ();

  jtag_debug_sys_avalon_host #(
    .ADDR_W(2), .DATA_W(32), .READ_LATENCY(0), .TIMEOUT(TO)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );

  jtag_debug_sys_avalon_host #(
    .ADDR_W(2), .DATA_W(32), .READ_LATENCY(RL_B), .TIMEOUT(TO)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  // stimulus
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_address = 2'd0;
  logic [31:0] cmd_writedata = 32'd0;
  logic        rsp_ready = 1'b0;
  int          wait_len = 0;
  int          cs_run = 0;

  // slaves
  logic [4:0]  slave_reg = 5'd0;
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [31:0] s1_d = 32'd0, s2_d = 32'd0;

  assign ifa.cmd_valid     = cmd_valid & ~sel;
  assign ifa.cmd_write     = cmd_write;
  assign ifa.cmd_address   = cmd_address;
  assign ifa.cmd_writedata = cmd_writedata;
  assign ifa.rsp_ready     = rsp_ready & ~sel;
  assign ifa.waitrequest   = ifa.chipselect && (cs_run < wait_len);
  assign ifa.readdata      = (ifa.address == 2'd0) ? {27'd0, slave_reg} : 32'd0;

  assign ifb.cmd_valid     = cmd_valid & sel;
  assign ifb.cmd_write     = cmd_write;
  assign ifb.cmd_address   = cmd_address;
  assign ifb.cmd_writedata = cmd_writedata;
  assign ifb.rsp_ready     = rsp_ready & sel;
  assign ifb.waitrequest   = ifb.chipselect && (cs_run < wait_len);
  assign ifb.readdata      = s2_v ? s2_d : 32'hDEADBEEF;

  logic        d_cmd_ready, d_rsp_valid, d_rsp_error, d_cs, d_write_n;
  logic [31:0] d_rsp_readdata, d_writedata;
  logic [1:0]  d_address;
  assign d_cmd_ready    = sel ? ifb.cmd_ready    : ifa.cmd_ready;
  assign d_rsp_valid    = sel ? ifb.rsp_valid    : ifa.rsp_valid;
  assign d_rsp_error    = sel ? ifb.rsp_error    : ifa.rsp_error;
  assign d_rsp_readdata = sel ? ifb.rsp_readdata : ifa.rsp_readdata;
  assign d_cs           = sel ? ifb.chipselect   : ifa.chipselect;
  assign d_write_n      = sel ? ifb.write_n      : ifa.write_n;
  assign d_writedata    = sel ? ifb.writedata    : ifa.writedata;
  assign d_address      = sel ? ifb.address      : ifa.address;

  // waitrequest runs for wait_len cycles of each chipselect burst
  always @(posedge clk) cs_run <= d_cs ? cs_run + 1 : 0;

  // PIO slave: 5-bit register at address 0
  always @(posedge clk)
    if (ifa.chipselect && !ifa.write_n && !ifa.waitrequest && ifa.address == 2'd0)
      slave_reg <= ifa.writedata[4:0];

  // latency-2 slave: data valid in the second cycle after the access
  always @(posedge clk) begin
    s1_v <= ifb.chipselect && ifb.write_n && !ifb.waitrequest;
    s1_d <= 32'hA5A5A5A5 + 32'(ifb.address);
    s2_v <= s1_v;
    s2_d <= s1_d;
  end

  int total = 0;
  int bad = 0;
  int prints = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      if (prints < 40) begin
        prints = prints + 1;
        $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

  // model state
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        active = 1'b0;
  logic        mdl_sel = 1'b0, mdl_write = 1'b0, mdl_err = 1'b0;
  logic [1:0]  mdl_addr = 2'd0;
  logic [31:0] mdl_wdata = 32'd0, mdl_data = 32'd0;
  int          mdl_cs = 0, mdl_lat = 0;
  logic [4:0]  shadow = 5'd0;
  int          act_cs = 0, act_lat = 0;
  int          last_cs = 0, last_lat = 0;
  logic [31:0] last_rd = 32'd0;
  logic        last_err = 1'b0;

  // per-cycle comparison against the transaction model
  always @(negedge clk) begin : cmp
    int   n;
    logic e_cs, e_rv, to;
    cyc = cyc + 1;
    if (reset) begin
      active = 1'b0;
    end else begin
      n    = cyc - acc_cyc;
      e_cs = active && (n >= 1) && (n <= mdl_cs);
      e_rv = active && (n >= mdl_lat);
      if (active && d_cs) act_cs = act_cs + 1;
      if (active && d_rsp_valid && act_lat == 0) act_lat = n;
      if (e_rv && n == mdl_lat && mdl_write && !mdl_err && mdl_addr == 2'd0 && !mdl_sel)
        shadow = mdl_wdata[4:0];
      chk("cmd_ready", 32'(d_cmd_ready), 32'(!active));
      chk("chipselect", 32'(d_cs), 32'(e_cs));
      chk("write_n", 32'(d_write_n), 32'(!(e_cs && mdl_write)));
      chk("rsp_valid", 32'(d_rsp_valid), 32'(e_rv));
      if (e_cs) chk("address", 32'(d_address), 32'(mdl_addr));
      if (e_cs && mdl_write) chk("writedata", d_writedata, mdl_wdata);
      if (e_rv) begin
        chk("rsp_readdata", d_rsp_readdata, mdl_data);
        chk("rsp_error", 32'(d_rsp_error), 32'(mdl_err));
      end
      if (!active) chk("slave_reg", 32'(slave_reg), 32'(shadow));
      if (e_rv && rsp_ready) begin
        last_rd  = d_rsp_readdata;
        last_err = d_rsp_error;
        last_cs  = act_cs;
        last_lat = act_lat;
        active   = 1'b0;
      end else if (!active && cmd_valid) begin
        to        = (wait_len >= TO);
        active    = 1'b1;
        acc_cyc   = cyc;
        act_cs    = 0;
        act_lat   = 0;
        mdl_sel   = sel;
        mdl_write = cmd_write;
        mdl_addr  = cmd_address;
        mdl_wdata = cmd_writedata;
        mdl_err   = to;
        mdl_cs    = to ? TO : wait_len + 1;
        mdl_lat   = mdl_cs + 1 + ((!to && !cmd_write && sel) ? RL_B : 0);
        if (to || cmd_write) mdl_data = 32'd0;
        else if (sel)        mdl_data = 32'hA5A5A5A5 + 32'(cmd_address);
        else                 mdl_data = (cmd_address == 2'd0) ? {27'd0, shadow} : 32'd0;
      end
    end
  end

  task automatic do_txn(input logic s, input logic w, input logic [1:0] a,
                        input logic [31:0] d, input int wl, input int rdly,
                        input logic early, input logic junk);
    int k;
    @(posedge clk); #1;
    sel = s; wait_len = wl; rsp_ready = early;
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_writedata = d;
    @(posedge clk); #1;
    if (junk) begin
      cmd_write     = 1'($urandom_range(0, 1));
      cmd_address   = 2'($urandom_range(0, 3));
      cmd_writedata = $urandom;
    end else begin
      cmd_valid = 1'b0;
    end
    k = 0;
    while (!d_rsp_valid && k < 100) begin
      @(posedge clk); #1;
      k = k + 1;
    end
    chk("rsp_seen", 32'(d_rsp_valid), 32'd1);
    cmd_valid = 1'b0;
    if (!early) begin
      repeat (rdly) begin @(posedge clk); #1; end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    wait_len  = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(d_cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(d_rsp_valid), 32'd0);
    chk({tag, "_rsp_error"}, 32'(d_rsp_error), 32'd0);
    chk({tag, "_rsp_readdata"}, d_rsp_readdata, 32'd0);
    chk({tag, "_chipselect"}, 32'(d_cs), 32'd0);
    chk({tag, "_write_n"}, 32'(d_write_n), 32'd1);
    chk({tag, "_address"}, 32'(d_address), 32'd0);
    chk({tag, "_writedata"}, d_writedata, 32'd0);
  endtask

  int wl_tab[8] = '{0, 0, 1, 2, 3, 7, 8, 12};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #1; chk_reset_vals("rst_a");
    sel = 1'b1; #1; chk_reset_vals("rst_b");
    sel = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // write 0x15 to the PIO register
    do_txn(1'b0, 1'b1, 2'd0, 32'h15, 0, 0, 1'b0, 1'b0);
    chk("t1_cs_cycles", 32'(last_cs), 32'd1);
    chk("t1_latency", 32'(last_lat), 32'd2);
    chk("t1_err", 32'(last_err), 32'd0);
    chk("t1_slave_reg", 32'(slave_reg), 32'h15);

    // read back address 0 and an empty address
    do_txn(1'b0, 1'b0, 2'd0, 32'h0, 0, 1, 1'b0, 1'b0);
    chk("t2_rd0", last_rd, 32'h00000015);
    do_txn(1'b0, 1'b0, 2'd1, 32'h0, 0, 0, 1'b0, 1'b0);
    chk("t2_rd1", last_rd, 32'h0);

    // three waitrequest cycles on a write
    do_txn(1'b0, 1'b1, 2'd0, 32'h0C, 3, 0, 1'b0, 1'b0);
    chk("t3_cs_cycles", 32'(last_cs), 32'd4);
    chk("t3_err", 32'(last_err), 32'd0);

    // stuck waitrequest times out, then normal service resumes
    do_txn(1'b0, 1'b1, 2'd0, 32'h1E, 1000, 0, 1'b0, 1'b0);
    chk("t4_cs_cycles", 32'(last_cs), 32'd8);
    chk("t4_err", 32'(last_err), 32'd1);
    chk("t4_rd", last_rd, 32'd0);
    chk("t4_reg_kept", 32'(slave_reg), 32'h0C);
    do_txn(1'b0, 1'b1, 2'd0, 32'h03, 0, 0, 1'b0, 1'b0);
    chk("t4_next_err", 32'(last_err), 32'd0);
    chk("t4_next_reg", 32'(slave_reg), 32'h03);

    // latency-2 read with response held off for 5 cycles
    do_txn(1'b1, 1'b0, 2'd0, 32'h0, 0, 5, 1'b0, 1'b0);
    chk("t5_rd", last_rd, 32'hA5A5A5A5);
    chk("t5_latency", 32'(last_lat), 32'd4);

    // reset in the middle of a stalled write
    @(posedge clk); #1;
    sel = 1'b0; wait_len = 1000;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd0; cmd_writedata = 32'h1F;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_cs_before", 32'(d_cs), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_cs", 32'(d_cs), 32'd0);
    chk("t6_write_n", 32'(d_write_n), 32'd1);
    chk("t6_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("t6_cmd_ready", 32'(d_cmd_ready), 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0; wait_len = 0;
    chk("t6_reg_kept", 32'(slave_reg), 32'h03);
    do_txn(1'b0, 1'b1, 2'd0, 32'h0A, 0, 0, 1'b0, 1'b0);
    chk("t6_cs_cycles", 32'(last_cs), 32'd1);
    chk("t6_reg", 32'(slave_reg), 32'h0A);

    // randomized traffic on both hosts
    repeat (150) begin
      logic        s, w, e, j;
      logic [1:0]  a;
      logic [31:0] d;
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      d = $urandom;
      e = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 3) == 0);
      do_txn(s, w, a, d, wl_tab[$urandom_range(0, 7)], $urandom_range(0, 3), e, j);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
